// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, AES-128 round count, controller state
// encoding, and the byte-level round transforms used by the round datapath.
// Byte 0 of a block is bits [127:120]. The state is column-major, so byte i
// sits at row i%4, column i/4.
package aes_pkg;

  localparam int NR_AES128 = 10;
  localparam int BLOCK_W   = 128;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  typedef logic [0:15][7:0] blk_t;

  localparam logic [0:255][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic blk_t sub_bytes(input blk_t s);
    blk_t r;
    for (int i = 0; i < 16; i++) r[i] = SBOX_TBL[s[i]];
    return r;
  endfunction

  // Row r rotates left by r columns.
  function automatic blk_t shift_rows(input blk_t s);
    blk_t r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[4*c + w] = s[4*((c + w) % 4) + w];
    return r;
  endfunction

  function automatic blk_t mix_columns(input blk_t s);
    blk_t r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[4*c];
      a1 = s[4*c + 1];
      a2 = s[4*c + 2];
      a3 = s[4*c + 3];
      r[4*c]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[4*c + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[4*c + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[4*c + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One AES round, purely combinational:
//   result = [MixColumns](ShiftRows(SubBytes(state))) ^ key
// Ports:
//   state  in  128  current cipher state
//   key    in  128  round key for this round
//   last   in  1    final round: MixColumns is bypassed
//   result out 128  next cipher state
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] key,
  input  logic         last,
  output logic [127:0] result
);

  blk_t sr;
  blk_t mc;

  assign sr     = shift_rows(sub_bytes(state));
  assign mc     = mix_columns(sr);
  assign result = (last ? sr : mc) ^ key;

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption sequencer. One block is accepted in IDLE, the
// initial AddRoundKey is applied on the accept edge, then NR rounds run
// through a single shared round datapath. The result is held in DONE until
// the downstream takes it.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_valid/in_ready    block input handshake, in_block is the plaintext
//   rk_idx/rk_data       round-key store address and same-cycle key data
//   out_valid/out_ready  ciphertext handshake, out_block is the state register
//   busy                 high while a block is in flight (ROUND, DONE)
//
// state | meaning
// IDLE  | waiting for a block, key 0 presented
// ROUND | applying round rnd with key rnd (rnd = 1..NR)
// DONE  | ciphertext presented, waiting for out_ready
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR  = NR_AES128,
  parameter int RKW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_block,
  output logic [RKW-1:0]   rk_idx,
  input  logic [127:0]     rk_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_block,
  output logic             busy
);

  state_t         st_q, st_d;
  logic [RKW-1:0] rnd_q, rnd_d;
  logic [127:0]   state_q, state_d;
  logic [127:0]   round_out;
  logic           last;

  assign last = (rnd_q == RKW'(NR));

  aes_round_comb u_round (
    .state  (state_q),
    .key    (rk_data),
    .last   (last),
    .result (round_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      rnd_q   <= '0;
      state_q <= '0;
    end else begin
      st_q    <= st_d;
      rnd_q   <= rnd_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    st_d      = st_q;
    rnd_d     = rnd_q;
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rk_idx    = '0;
    case (st_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = in_block ^ rk_data;
          rnd_d   = RKW'(1);
          st_d    = ROUND;
        end
      end
      ROUND: begin
        busy    = 1'b1;
        rk_idx  = rnd_q;
        state_d = round_out;
        if (last) begin
          rnd_d = '0;
          st_d  = DONE;
        end else begin
          rnd_d = rnd_q + 1'b1;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  assign out_block = state_q;

endmodule
